uart_sector_rx: RTL and testbench

// Host-to-card half of the UART/SD example path: receives 8N1 UART bytes from the host PC, assembles

---
 rtl/sd_uart_pkg.sv | 15 +
 rtl/uart_rx_core.sv | 116 +++++++++++
 rtl/uart_sector_rx.sv | 145 ++++++++++++++
 tb/tb_uart_sector_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sd_uart_pkg.sv
// Shared types and constants for the UART <-> SD sector example path.
package sd_uart_pkg;

   // UART receiver states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int unsigned UART_CLK_DIV_115200 = 868;
   localparam int unsigned SECTOR_BYTES        = 512;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, bit timer and rx FSM.
module uart_rx_core
   import sd_uart_pkg::*;
#(
   parameter int unsigned CLK_DIV = UART_CLK_DIV_115200
) (
   input  logic       clk100mhz,
   input  logic       resetn,
   input  logic       uart_rx,
   output logic [7:0] rx_byte,
   output logic       rx_strobe,
   output logic       frame_err,
   output logic       idle_c,
   output logic       fall_c
);

   localparam int unsigned TW = $clog2(CLK_DIV);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(CLK_DIV - 1);

   logic [1:0]    sync_q;
   logic          rx_prev_q;
   logic          rx_s;
   rx_state_t     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    byte_q, byte_d;
   logic          strobe_q, strobe_d;
   logic          ferr_q, ferr_d;

   assign rx_s      = sync_q[1];
   assign fall_c    = rx_prev_q & ~rx_s;
   assign idle_c    = (state_q == IDLE);
   assign rx_byte   = byte_q;
   assign rx_strobe = strobe_q;
   assign frame_err = ferr_q;

   // Synchroniser and edge-detect history, idle-high out of reset
   always_ff @(posedge clk100mhz or negedge resetn) begin
      if (!resetn) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[0], uart_rx};
         rx_prev_q <= sync_q[1];
      end
   end

   // FSM and datapath registers
   always_ff @(posedge clk100mhz or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         byte_q   <= '0;
         strobe_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         byte_q   <= byte_d;
         strobe_q <= strobe_d;
         ferr_q   <= ferr_d;
      end
   end

   // Next-state: start-bit qualify at half bit, then sample mid-bit
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q + TW'(1);
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      byte_d   = byte_q;
      strobe_d = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (fall_c) state_d = START;
         end
         START: begin
            if (timer_q == HALF_LAST) begin
               timer_d = '0;
               bit_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer_q == FULL_LAST) begin
               timer_d = '0;
               shreg_d = {rx_s, shreg_q[7:1]};
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         STOP: begin
            if (timer_q == FULL_LAST) begin
               timer_d = '0;
               state_d = IDLE;
               if (rx_s) begin
                  strobe_d = 1'b1;
                  byte_d   = shreg_q;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/uart_sector_rx.sv
// Assembles received UART bytes into ping-pong sector banks for an SD writer.
module uart_sector_rx #(
   parameter int unsigned CLK_DIV      = sd_uart_pkg::UART_CLK_DIV_115200,
   parameter int unsigned SECTOR_BYTES = sd_uart_pkg::SECTOR_BYTES,
   parameter int unsigned IDLE_TIMEOUT = 10_000_000
) (
   input  logic                            clk100mhz,
   input  logic                            resetn,
   input  logic                            uart_rx,
   output logic                            sector_valid,
   input  logic [$clog2(SECTOR_BYTES)-1:0] rd_addr,
   output logic [7:0]                      rd_data,
   input  logic                            sector_done,
   output logic [$clog2(SECTOR_BYTES):0]   fill_count,
   output logic                            frame_err,
   output logic                            overrun,
   output logic                            timeout
);

   localparam int unsigned AW = $clog2(SECTOR_BYTES);
   localparam int unsigned FW = AW + 1;
   localparam int unsigned CW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [FW-1:0] FILL_LAST = FW'(SECTOR_BYTES - 1);
   localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT - 1);

   logic [7:0]    rx_byte;
   logic          rx_strobe;
   logic          idle_c;
   logic          fall_c;

   logic [7:0]    mem [2*SECTOR_BYTES];
   logic [1:0]    full_q, full_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
   logic          overrun_q, overrun_d;
   logic          timeout_q, timeout_d;
   logic          valid_q, valid_d;
   logic          we_c;
   logic          release_c;
   logic [7:0]    rd_data_q;

   uart_rx_core #(
      .CLK_DIV (CLK_DIV)
   ) u_core (
      .clk100mhz (clk100mhz),
      .resetn    (resetn),
      .uart_rx   (uart_rx),
      .rx_byte   (rx_byte),
      .rx_strobe (rx_strobe),
      .frame_err (frame_err),
      .idle_c    (idle_c),
      .fall_c    (fall_c)
   );

   assign sector_valid = valid_q;
   assign fill_count   = fill_q;
   assign overrun      = overrun_q;
   assign timeout      = timeout_q;
   assign rd_data      = rd_data_q;

   // Bank status, handshake and idle-timeout state
   always_ff @(posedge clk100mhz or negedge resetn) begin
      if (!resetn) begin
         full_q     <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         fill_q     <= '0;
         idle_cnt_q <= '0;
         overrun_q  <= 1'b0;
         timeout_q  <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         full_q     <= full_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         fill_q     <= fill_d;
         idle_cnt_q <= idle_cnt_d;
         overrun_q  <= overrun_d;
         timeout_q  <= timeout_d;
         valid_q    <= valid_d;
      end
   end

   // Next bank state; a release forces one low cycle of sector_valid
   always_comb begin
      full_d     = full_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      fill_d     = fill_q;
      idle_cnt_d = idle_cnt_q;
      overrun_d  = overrun_q;
      timeout_d  = 1'b0;
      we_c       = 1'b0;
      release_c  = 1'b0;

      if (rx_strobe) begin
         if (!full_q[wr_bank_q]) begin
            we_c = 1'b1;
            if (fill_q == FILL_LAST) begin
               full_d[wr_bank_q] = 1'b1;
               fill_d            = '0;
               wr_bank_d         = ~wr_bank_q;
            end else begin
               fill_d = fill_q + FW'(1);
            end
         end else begin
            overrun_d = 1'b1;
         end
      end

      if (sector_done && valid_q) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
         release_c         = 1'b1;
      end

      if (idle_c && (fill_q != '0) && !fall_c) begin
         if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_d = '0;
            fill_d     = '0;
            timeout_d  = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
         end
      end else begin
         idle_cnt_d = '0;
      end

      valid_d = full_d[rd_bank_d] && !release_c;
   end

   // Bank RAM write port
   always_ff @(posedge clk100mhz) begin
      if (we_c) mem[{wr_bank_q, fill_q[AW-1:0]}] <= rx_byte;
   end

   // Registered read of the pending bank
   always_ff @(posedge clk100mhz or negedge resetn) begin
      if (!resetn) rd_data_q <= '0;
      else         rd_data_q <= mem[{rd_bank_q, rd_addr}];
   end

endmodule

// File: tb/tb_uart_sector_rx.sv
// Directed bench for uart_sector_rx; sector shrunk to 32 bytes to keep the run short.
module tb_uart_sector_rx;

   localparam int unsigned DIV = 16;
   localparam int unsigned SB  = 32;
   localparam int unsigned TMO = 2000;

   logic       clk100mhz = 1'b0;
   logic       resetn    = 1'b0;
   logic       uart_rx   = 1'b1;
   logic       sector_valid;
   logic [4:0] rd_addr   = '0;
   logic [7:0] rd_data;
   logic       sector_done = 1'b0;
   logic [5:0] fill_count;
   logic       frame_err;
   logic       overrun;
   logic       timeout;

   int checks   = 0;
   int failures = 0;
   int ferr_seen = 0;
   int tmo_seen  = 0;

   uart_sector_rx #(
      .CLK_DIV      (DIV),
      .SECTOR_BYTES (SB),
      .IDLE_TIMEOUT (TMO)
   ) dut (
      .clk100mhz    (clk100mhz),
      .resetn       (resetn),
      .uart_rx      (uart_rx),
      .sector_valid (sector_valid),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .sector_done  (sector_done),
      .fill_count   (fill_count),
      .frame_err    (frame_err),
      .overrun      (overrun),
      .timeout      (timeout)
   );

   always #5 clk100mhz = ~clk100mhz;

   // Pulse counters
   always @(negedge clk100mhz) begin
      if (frame_err === 1'b1) ferr_seen++;
      if (timeout === 1'b1)   tmo_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clk100mhz);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (DIV) @(negedge clk100mhz);
      end
      uart_rx = stop_bit;
      repeat (DIV) @(negedge clk100mhz);
      uart_rx = 1'b1;
      repeat (4) @(negedge clk100mhz);
   endtask

   task automatic read_byte(input logic [4:0] a, input logic [7:0] exp, input string tag);
      rd_addr = a;
      @(negedge clk100mhz);
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic pulse_done();
      sector_done = 1'b1;
      @(negedge clk100mhz);
      sector_done = 1'b0;
   endtask

   initial begin
      int f0;
      // Reset state
      repeat (3) @(negedge clk100mhz);
      chk("rst_valid", 32'(sector_valid), 0);
      chk("rst_fill", 32'(fill_count), 0);
      chk("rst_ovr", 32'(overrun), 0);
      chk("rst_rdata", 32'(rd_data), 0);
      resetn = 1'b1;
      repeat (5) @(negedge clk100mhz);

      // Sector of i; valid appears with the last byte
      for (int i = 0; i < SB - 1; i++) send_byte(8'(i), 1'b1);
      chk("s1_fill31", 32'(fill_count), 31);
      chk("s1_valid_pre", 32'(sector_valid), 0);
      send_byte(8'(SB - 1), 1'b1);
      chk("s1_valid", 32'(sector_valid), 1);
      chk("s1_fill0", 32'(fill_count), 0);
      read_byte(5'd5, 8'h05, "s1_rd5");
      read_byte(5'd20, 8'h14, "s1_rd20");
      pulse_done();
      chk("s1_done", 32'(sector_valid), 0);

      // Framing error then a good byte at index 0
      f0 = ferr_seen;
      send_byte(8'hA5, 1'b0);
      chk("ferr_pulse", 32'(ferr_seen - f0), 1);
      chk("ferr_fill", 32'(fill_count), 0);
      send_byte(8'h3C, 1'b1);
      chk("ferr_next_fill", 32'(fill_count), 1);
      for (int i = 1; i < SB; i++) send_byte(8'(8'h40 + i), 1'b1);
      chk("s2_valid", 32'(sector_valid), 1);

      // Fill second bank, then overrun
      for (int i = 0; i < SB; i++) send_byte(8'(8'h80 + i), 1'b1);
      read_byte(5'd0, 8'h3C, "s2_rd0");
      chk("ovr_pre", 32'(overrun), 0);
      send_byte(8'hFF, 1'b1);
      chk("ovr_set", 32'(overrun), 1);
      chk("ovr_fill", 32'(fill_count), 0);
      rd_addr = 5'd0;
      pulse_done();
      chk("rel_drop", 32'(sector_valid), 0);
      @(negedge clk100mhz);
      chk("rel_reassert", 32'(sector_valid), 1);
      read_byte(5'd0, 8'h80, "s3_rd0");
      pulse_done();
      chk("s3_done", 32'(sector_valid), 0);
      pulse_done();
      @(negedge clk100mhz);
      chk("spurious_done", 32'(sector_valid), 0);

      // Partial sector discarded by idle timeout
      for (int i = 0; i < 10; i++) send_byte(8'hEE, 1'b1);
      chk("tmo_fill10", 32'(fill_count), 10);
      chk("tmo_none_yet", 32'(tmo_seen), 0);
      repeat (1900) @(negedge clk100mhz);
      chk("tmo_not_early", 32'(tmo_seen), 0);
      repeat (200) @(negedge clk100mhz);
      chk("tmo_pulse", 32'(tmo_seen), 1);
      chk("tmo_fill0", 32'(fill_count), 0);
      for (int i = 0; i < SB; i++) send_byte(8'(8'hC0 + i), 1'b1);
      chk("s4_valid", 32'(sector_valid), 1);
      read_byte(5'd7, 8'hC7, "s4_rd7");
      read_byte(5'd0, 8'hC0, "s4_rd0");
      pulse_done();

      // Glitch shorter than half a bit
      f0 = ferr_seen;
      uart_rx = 1'b0;
      repeat (6) @(negedge clk100mhz);
      uart_rx = 1'b1;
      repeat (40) @(negedge clk100mhz);
      chk("glitch_fill", 32'(fill_count), 0);
      chk("glitch_ferr", 32'(ferr_seen - f0), 0);
      send_byte(8'h5A, 1'b1);
      chk("glitch_next", 32'(fill_count), 1);

      // Reset in the middle of a byte and a sector
      for (int i = 1; i < 20; i++) send_byte(8'h11, 1'b1);
      chk("mid_fill", 32'(fill_count), 20);
      chk("mid_ovr_sticky", 32'(overrun), 1);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clk100mhz);
      for (int i = 0; i < 4; i++) begin
         uart_rx = i[0];
         repeat (DIV) @(negedge clk100mhz);
      end
      uart_rx = 1'b0;
      repeat (DIV / 2) @(negedge clk100mhz);
      resetn = 1'b0;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk100mhz);
      chk("mrst_valid", 32'(sector_valid), 0);
      chk("mrst_fill", 32'(fill_count), 0);
      chk("mrst_ovr", 32'(overrun), 0);
      chk("mrst_rdata", 32'(rd_data), 0);
      resetn = 1'b1;
      repeat (30) @(negedge clk100mhz);
      chk("mrst_idle_fill", 32'(fill_count), 0);
      for (int i = 0; i < SB; i++) send_byte(8'(i * 3), 1'b1);
      chk("s5_valid", 32'(sector_valid), 1);
      read_byte(5'd31, 8'h5D, "s5_rd31");
      read_byte(5'd10, 8'h1E, "s5_rd10");
      chk("s5_ovr", 32'(overrun), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
